// File: rtl/spislave.sv
// SPI mode-0 receiver with Avalon-MM drained word FIFO.
// Define SPISLAVE_OVERFLOW_EN for the sticky overflow flag on readdata[29].
module spislave #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic        coe_sclk,
  input  logic        coe_mosi,
  input  logic        coe_csn,
  input  logic        coe_dcn,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [1:0] csn_q;
  logic [1:0] dcn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      mosi_q <= '0;
      csn_q  <= '1;
      dcn_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], coe_sclk};
      mosi_q <= {mosi_q[0], coe_mosi};
      csn_q  <= {csn_q[0], coe_csn};
      dcn_q  <= {dcn_q[0], coe_dcn};
    end
  end

  logic sclk_rise;
  logic csn_s;
  logic flush;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign csn_s     = csn_q[1];
  assign flush     = avs_write & avs_writedata[0];

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  shift_q;
  logic [N:0]    shift_ext;
  logic [N-1:0]  shift_nx;
  logic          push_q;
  logic [N:0]    pword_q;

  // Extended concat keeps the shift legal for N == 1.
  assign shift_ext = {shift_q, mosi_q[1]};
  assign shift_nx  = shift_ext[N-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      pword_q <= '0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!csn_s) state_q <= SHIFT;
        end
        SHIFT: begin
          if (csn_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (flush) begin
            cnt_q <= '0;
          end else if (sclk_rise) begin
            shift_q <= shift_nx;
            if (cnt_q == CW'(N - 1)) begin
              cnt_q   <= '0;
              push_q  <= 1'b1;
              pword_q <= {dcn_q[1], shift_nx};
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [N:0]    mem [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic          ovf;
  logic [N:0]    head;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = avs_read & ~empty & ~flush;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_q & (~full | do_pop) & ~flush;
  assign drop    = push_q & full & ~do_pop & ~flush;
  assign head    = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      rptr_q <= wptr_q;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= pword_q;
  end

  logic unused_wdata;

`ifdef SPISLAVE_OVERFLOW_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                ovf_q <= 1'b0;
    else if (drop)                            ovf_q <= 1'b1;
    else if (avs_write && avs_writedata[1])   ovf_q <= 1'b0;
  end
  assign ovf          = ovf_q;
  assign unused_wdata = ^avs_writedata[31:2];
`else
  assign ovf          = 1'b0;
  assign unused_wdata = ^{avs_writedata[31:1], drop};
`endif

  always_comb begin
    avs_readdata     = '0;
    avs_readdata[29] = ovf;
    if (!empty) begin
      avs_readdata[31]    = 1'b1;
      avs_readdata[30]    = head[N];
      avs_readdata[N-1:0] = head[N-1:0];
    end
  end

  assign irq = ~empty | ovf;

endmodule

// File: tb/tb_spislave.sv
// Self-checking bench for spislave: vector table, corner sequences and a random phase against a queue model.
module tb_spislave;
  localparam int N     = 16;
  localparam int DEPTH = 4;
`ifdef SPISLAVE_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        coe_sclk = 1'b0;
  logic        coe_mosi = 1'b0;
  logic        coe_csn = 1'b1;
  logic        coe_dcn = 1'b0;
  logic        irq;

  spislave #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .coe_sclk(coe_sclk), .coe_mosi(coe_mosi), .coe_csn(coe_csn),
    .coe_dcn(coe_dcn), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [N-1:0] w; logic d; } ent_t;
  ent_t mq[$];
  bit   m_ovf = 1'b0;
  logic [31:0] lat_rd;

  typedef struct { logic [N-1:0] w; logic d; logic [31:0] exp; } vec_t;
  vec_t tbl[4];

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    r[29] = m_ovf;
    if (mq.size() > 0) begin
      r[31] = 1'b1;
      r[30] = mq[0].d;
      r[N-1:0] = mq[0].w;
    end
    return r;
  endfunction

  function automatic void m_push(logic [N-1:0] w, logic d);
    ent_t e;
    e.w = w;
    e.d = d;
    if (mq.size() < DEPTH) mq.push_back(e);
    else if (OVF_EN) m_ovf = 1'b1;
  endfunction

  function automatic void m_pop();
    if (mq.size() > 0) void'(mq.pop_front());
  endfunction

  function automatic void m_write(logic [31:0] data);
    if (data[0]) mq.delete();
    if (data[1] && OVF_EN) m_ovf = 1'b0;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_state(string name);
    check(name, avs_readdata, exp_rd());
    check({name, "_irq"}, {31'b0, irq}, {31'b0, (mq.size() > 0) || m_ovf});
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(logic b);
    coe_mosi = b;
    tick(4);
    coe_sclk = 1'b1;
    tick(4);
    coe_sclk = 1'b0;
  endtask

  task automatic cs_low();
    coe_csn = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    coe_csn = 1'b1;
    tick(6);
  endtask

  task automatic send_word(logic [N-1:0] w, logic d);
    coe_dcn = d;
    for (int i = N - 1; i >= 0; i--) spi_bit(w[i]);
  endtask

  // act: 0 none, 1 avs_read, 2 flush write -- applied on the push edge (4th clk after the last SCLK rise).
  task automatic send_timed(logic [N-1:0] w, logic d, int act);
    coe_dcn = d;
    for (int i = N - 1; i >= 1; i--) spi_bit(w[i]);
    coe_mosi = w[0];
    tick(4);
    coe_sclk = 1'b1;
    tick(3);
    if (act == 1) avs_read = 1'b1;
    if (act == 2) begin
      avs_write = 1'b1;
      avs_writedata = 32'h1;
    end
    tick(1);
    lat_rd = avs_readdata;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    tick(3);
    coe_sclk = 1'b0;
  endtask

  task automatic pop();
    avs_read = 1'b1;
    tick(1);
    avs_read = 1'b0;
    m_pop();
  endtask

  task automatic wr(logic [31:0] data);
    avs_write = 1'b1;
    avs_writedata = data;
    tick(1);
    avs_write = 1'b0;
    avs_writedata = '0;
    m_write(data);
  endtask

  task automatic drain(string name);
    while (mq.size() > 0) begin
      check_state(name);
      pop();
    end
    check_state({name, "_empty"});
  endtask

  initial begin
    logic [N-1:0] rw;
    logic         rd;
    int           op;
    int           k;

    tbl[0] = '{16'h0001, 1'b1, 32'hC000_0001};
    tbl[1] = '{16'h8000, 1'b1, 32'hC000_8000};
    tbl[2] = '{16'hFFFF, 1'b0, 32'h8000_FFFF};
    tbl[3] = '{16'h1234, 1'b1, 32'hC000_1234};

    // Reset values, then reset mid-frame.
    tick(3);
    check_state("reset");
    reset = 1'b0;
    tick(2);
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    reset = 1'b1;
    #2;
    check("midreset_rd", avs_readdata, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    coe_csn = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
    cs_low();
    send_word(16'h3C96, 1'b0);
    m_push(16'h3C96, 1'b0);
    cs_high();
    check_state("after_reset");
    drain("after_reset");

    // Single word with latency bound.
    cs_low();
    send_timed(16'hA5C3, 1'b1, 0);
    m_push(16'hA5C3, 1'b1);
    check("single_latency", lat_rd, 32'hC000_A5C3);
    cs_high();
    check("single_irq", {31'b0, irq}, 32'h1);
    pop();
    check("single_popped", avs_readdata, {2'b0, m_ovf, 29'b0});
    check_state("single_popped");

    // Back-to-back words in one frame, from the vector table.
    cs_low();
    foreach (tbl[i]) begin
      send_word(tbl[i].w, tbl[i].d);
      m_push(tbl[i].w, tbl[i].d);
    end
    cs_high();
    foreach (tbl[i]) begin
      check($sformatf("b2b_%0d", i), avs_readdata, tbl[i].exp);
      pop();
    end
    check_state("b2b_empty");

    // Abort after 7 bits, empty read, then aligned word.
    cs_low();
    for (int i = 0; i < 7; i++) spi_bit(1'($urandom_range(0, 1)));
    cs_high();
    check_state("abort");
    pop();
    check_state("empty_read");
    cs_low();
    send_word(16'h6E01, 1'b1);
    m_push(16'h6E01, 1'b1);
    cs_high();
    check("aligned", avs_readdata, 32'hC000_6E01);
    drain("aligned");

    // Overflow: five words, no reads.
    cs_low();
    for (int i = 0; i < 5; i++) begin
      rw = N'(16'h1100 + i);
      send_word(rw, 1'(i));
      m_push(rw, 1'(i));
    end
    cs_high();
    check("ovf_bit", {31'b0, avs_readdata[29]}, {31'b0, OVF_EN});
    check_state("ovf");
    wr(32'h2);
    check("ovf_cleared", {31'b0, avs_readdata[29]}, 32'h0);
    drain("ovf");

    // Push and pop colliding while full.
    cs_low();
    for (int i = 0; i < 4; i++) begin
      rw = N'(16'h2200 + i);
      send_word(rw, 1'b0);
      m_push(rw, 1'b0);
    end
    send_timed(16'h22FF, 1'b1, 1);
    m_pop();
    m_push(16'h22FF, 1'b1);
    cs_high();
    check("full_collide_no_ovf", {31'b0, avs_readdata[29]}, 32'h0);
    drain("full_collide");

    // Push and pop colliding while empty.
    cs_low();
    send_timed(16'h0F0F, 1'b0, 1);
    m_pop();
    m_push(16'h0F0F, 1'b0);
    check("empty_collide", lat_rd, 32'h8000_0F0F);
    cs_high();
    drain("empty_collide");

    // Flush coinciding with a push.
    cs_low();
    send_word(16'h0101, 1'b1);
    m_push(16'h0101, 1'b1);
    send_word(16'h0202, 1'b1);
    m_push(16'h0202, 1'b1);
    send_timed(16'h0303, 1'b1, 2);
    m_write(32'h1);
    check("flush_collide", lat_rd, exp_rd());
    cs_high();
    check_state("flush_collide");

    // Randomized operations against the queue model.
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          cs_low();
          k = $urandom_range(1, 3);
          for (int j = 0; j < k; j++) begin
            rw = N'($urandom);
            rd = 1'($urandom_range(0, 1));
            send_word(rw, rd);
            m_push(rw, rd);
          end
          cs_high();
        end
        1: begin
          k = $urandom_range(1, 2);
          for (int j = 0; j < k; j++) begin
            check_state("rnd_pre_pop");
            pop();
          end
        end
        2: begin
          cs_low();
          k = $urandom_range(1, N - 1);
          for (int j = 0; j < k; j++) spi_bit(1'($urandom_range(0, 1)));
          cs_high();
        end
        default: wr(32'($urandom_range(0, 3)));
      endcase
      check_state($sformatf("rnd_%0d", it));
    end
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spislave.md
Name: spislave

Overview:
- SPI receiver: the far end of the team's SPI master link. Accepts N-bit words on SCLK/MOSI/CS*/D/C* from an external or loopback master.
- Synchronizes the SPI pins into the system clock domain, deserializes MSB-first, tags each word with its D/C* level, and buffers words in a small FIFO.
- Software drains the FIFO through an Avalon-MM slave port. Used for loopback verification of the SPI master and as a display-side command/data sniffer.

Parameters:
- N, 16, word length in bits; legal range 1..28.
- DEPTH, 4, FIFO depth in words; power of 2, minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; asynchronous, active-high.
- avs_read  input  1  Avalon read strobe; pops the FIFO head when non-empty.
- avs_write  input  1  Avalon write strobe.
- avs_writedata  input  32  Avalon write data (control bits).
- avs_readdata  output  32  Avalon read data; read latency 0.
- coe_sclk  input  1  SPI SCLK, mode 0 (idle low, sample on rising edge).
- coe_mosi  input  1  SPI MOSI.
- coe_csn  input  1  SPI CS*, active low.
- coe_dcn  input  1  SPI D/C*; 0 = command, 1 = data.
- irq  output  1  high while FIFO non-empty.

Behaviour:
- **Reset.** All outputs and state are cleared asynchronously on reset high:
  - FIFO empty, bit counter 0, shift register 0, overflow 0.
  - irq=0, avs_readdata=0.
- **Synchronizer.** coe_sclk, coe_mosi, coe_csn and coe_dcn each pass through a 2-flop synchronizer; csn synchronizer flops reset to 1, others to 0.
  - A third sclk flop provides rising-edge detect.
  - Requirement on the master: SCLK high and low phases each ≥ 3 clk periods.
- **FSM states:**
  - IDLE: synced csn=1. Bit counter held at 0.
  - SHIFT: synced csn=0. On each detected sclk rising edge, shift synced mosi into the LSB of the shift register and increment the counter.
  - Transitions: IDLE→SHIFT when synced csn falls; SHIFT→IDLE when synced csn rises.
- **Word completion.** On the Nth rising edge:
  - The word {dcn_sync, shift[N-1:0]} is pushed the following clk cycle.
  - Counter returns to 0 and the FSM stays in SHIFT, so back-to-back words within one CS* frame are supported.
  - D/C* is sampled at the Nth rising edge.
- **Partial word.** csn rising with counter ≠ 0 discards the partial word; no push.
- **Latency.** A completed word is visible on avs_readdata (bit 31 = 1) no later than 4 clk cycles after the Nth SCLK rising edge at the pins.
- **avs_readdata layout** (combinational from FIFO head):
  - [N-1:0] = word.
  - [30] = head D/C*.
  - [31] = FIFO non-empty.
  - [29] = overflow (see optional feature).
  - All other bits 0.
  - When empty, all bits are 0 apart from [29].
- **Pop.** avs_read while non-empty pops the head on that clk edge. avs_read while empty is ignored.
- **Simultaneous push and pop:** both happen; occupancy unchanged. When empty, the pushed word becomes head on the next cycle.
- **Push when full:** word dropped, FIFO unchanged. If full and pop occur in the same cycle, the push succeeds.
- **avs_write:**
  - writedata[0]=1 flushes the FIFO (occupancy 0) and resets the bit counter.
  - Flush takes priority over a simultaneous push or pop.
- **Pointers.** Read/write pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - full = same index, differing MSB.
  - empty = pointers equal.

Optional Feature:
- Macro: SPISLAVE_OVERFLOW_EN.
- When defined:
  - A sticky overflow flag sets on any dropped push and reads on avs_readdata[29].
  - avs_write with writedata[1]=1 clears it; a set and a clear in the same cycle leave it set.
  - irq = non-empty OR overflow.
- When undefined:
  - Bit 29 reads 0, writedata[1] is ignored, irq = non-empty.
  - No flag register is synthesized.

Test Plan:
- **Reset value:** reset high mid-frame → avs_readdata=0, irq=0; the next frame after release receives correctly.
- **Single word:** send 0xA5C3 with dcn=1, sclk period 8 clk → within 4 clk of the 16th edge, readdata=0xC000A5C3 and irq=1; avs_read → readdata=0, irq=0.
- **Back-to-back words:** 4 words (0x0001, 0x8000, 0xFFFF with dcn=0, 0x1234) in one CS* frame → read out in order; the third reads 0x8000FFFF.
- **Abort and empty read:** CS* deasserted after 7 bits → no word pushed; the next full word is received aligned. avs_read while empty → no pointer change.
- **Overflow:** 5 words into DEPTH=4 with no reads → first 4 retained, fifth dropped.
  - With SPISLAVE_OVERFLOW_EN: bit 29=1, cleared by writing 0x2.
  - Without: bit 29 stays 0.
- **Collisions:** push and pop in the same cycle when FIFO is full or empty → occupancy rules above hold. A flush write coinciding with a push → FIFO empty.
